// File: rtl/wb_arbiter_pkg.sv
// wb_arbiter_pkg: shared arbiter state/requester types and grant decode
package wb_arbiter_pkg;
  typedef enum logic [1:0] {IDLE, GNT_M0, GNT_M1} arb_state_e;
  typedef enum logic {M0, M1} master_e;
  function automatic logic [1:0] grant_of(input arb_state_e s);
    return s == GNT_M1 ? 2'b10 : s == GNT_M0 ? 2'b01 : 2'b00;
  endfunction
endpackage

// File: rtl/wb_bus_t.sv
// wb_bus_t: Wishbone classic bundle shared by requesters and memory side
interface wb_bus_t #(parameter int BW = 32);
  logic          cyc;
  logic          stb;
  logic          we;
  logic          ack;
  logic [BW/8-1:0] sel;
  logic [BW-1:0] adr;
  logic [BW-1:0] dat_w;
  logic [BW-1:0] dat_r;
  modport master(output cyc, stb, we, sel, adr, dat_w, input ack, dat_r);
  modport slave(input cyc, stb, we, sel, adr, dat_w, output ack, dat_r);
endinterface

// File: rtl/wb_arbiter_watchdog.sv
// wb_watchdog: counts unacknowledged strobe cycles and flags expiry at TIMEOUT
module wb_watchdog #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic rstn_i,
  input  logic count_en,
  input  logic clear,
  output logic expire
);
  localparam int CW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
  logic [CW-1:0] cnt_q, cnt_d;
  assign expire = (TIMEOUT != 0) && (cnt_q == CW'(TIMEOUT));
  // expiry clears itself so the counter never exceeds TIMEOUT
  assign cnt_d = (clear || expire || TIMEOUT == 0) ? '0 : cnt_q + CW'(count_en);
  always_ff @(posedge clk) cnt_q <= !rstn_i ? '0 : cnt_d;
endmodule

// File: rtl/wb_arbiter.sv
// wb_arbiter: two-requester Wishbone arbiter with bus lock, round-robin ties and ack watchdog
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int TIMEOUT = 64,
  parameter int BITSIZE = 32
) (
  input  logic       clk,
  input  logic       rstn_i,
  wb_bus_t.slave     wb_m0,
  wb_bus_t.slave     wb_m1,
  wb_bus_t.master    wb_s,
  output logic [1:0] grant_o,
  output logic       timeout_o
);
  arb_state_e state_q, state_d;
  master_e    last_q, last_d;
  logic [1:0] grant_q;
  logic       timeout_q;
  logic       g0, g1, sel_cyc, sel_stb, expire;
  assign g0 = state_q == GNT_M0;
  assign g1 = state_q == GNT_M1;
  assign sel_cyc = g0 ? wb_m0.cyc : g1 ? wb_m1.cyc : 1'b0;
  assign sel_stb = g0 ? wb_m0.stb : g1 ? wb_m1.stb : 1'b0;
  // an expiring cycle withdraws the strobe from the slave
  assign wb_s.cyc   = sel_cyc & ~expire;
  assign wb_s.stb   = sel_stb & ~expire;
  assign wb_s.we    = g0 ? wb_m0.we : g1 ? wb_m1.we : 1'b0;
  assign wb_s.sel   = g0 ? wb_m0.sel : g1 ? wb_m1.sel : '0;
  assign wb_s.adr   = g0 ? wb_m0.adr : g1 ? wb_m1.adr : '0;
  assign wb_s.dat_w = g0 ? wb_m0.dat_w : g1 ? wb_m1.dat_w : '0;
  assign wb_m0.ack   = rstn_i & g0 & (wb_s.ack | expire);
  assign wb_m1.ack   = rstn_i & g1 & (wb_s.ack | expire);
  assign wb_m0.dat_r = (rstn_i && g0 && wb_s.ack) ? wb_s.dat_r : {BITSIZE{1'b0}};
  assign wb_m1.dat_r = (rstn_i && g1 && wb_s.ack) ? wb_s.dat_r : {BITSIZE{1'b0}};
  assign grant_o   = grant_q;
  assign timeout_o = timeout_q;
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    case (state_q)
      IDLE:   state_d = (wb_m0.cyc && wb_m1.cyc) ? (last_q == M1 ? GNT_M0 : GNT_M1) :
                        wb_m0.cyc ? GNT_M0 : wb_m1.cyc ? GNT_M1 : IDLE;
      GNT_M0: if (!wb_m0.cyc) begin
        state_d = wb_m1.cyc ? GNT_M1 : IDLE;
        last_d  = M0;
      end
      GNT_M1: if (!wb_m1.cyc) begin
        state_d = wb_m0.cyc ? GNT_M0 : IDLE;
        last_d  = M1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rstn_i) begin
      state_q   <= IDLE;
      last_q    <= M1;
      grant_q   <= 2'b00;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      grant_q   <= grant_of(state_d);
      timeout_q <= timeout_q | (expire & ~wb_s.ack);
    end
  end
  wb_watchdog #(.TIMEOUT(TIMEOUT)) u_wdog (
    .clk      (clk),
    .rstn_i   (rstn_i),
    .count_en ((g0 | g1) & sel_stb & ~wb_s.ack),
    .clear    (wb_s.ack | (state_d != state_q)),
    .expire   (expire)
  );
endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: directed scenario checks of wb_arbiter with TIMEOUT=4
module tb_wb_arbiter;
  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic [1:0] grant;
  logic       tmo;
  int         cmp = 0;
  int         err = 0;
  wb_bus_t #(.BW(32)) m0_if();
  wb_bus_t #(.BW(32)) m1_if();
  wb_bus_t #(.BW(32)) s_if();
  always #5 clk = ~clk;
  wb_arbiter #(.TIMEOUT(4), .BITSIZE(32)) dut (
    .clk       (clk),
    .rstn_i    (rstn),
    .wb_m0     (m0_if),
    .wb_m1     (m1_if),
    .wb_s      (s_if),
    .grant_o   (grant),
    .timeout_o (tmo)
  );
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic idle_all();
    m0_if.cyc = 0; m0_if.stb = 0; m0_if.we = 0; m0_if.sel = 0; m0_if.adr = 0; m0_if.dat_w = 0;
    m1_if.cyc = 0; m1_if.stb = 0; m1_if.we = 0; m1_if.sel = 0; m1_if.adr = 0; m1_if.dat_w = 0;
    s_if.ack = 0; s_if.dat_r = 0;
  endtask
  task automatic drive_m(input int m, input logic c, input logic we, input logic [3:0] sel,
                         input logic [31:0] adr, input logic [31:0] dat);
    if (m == 0) begin
      m0_if.cyc = c; m0_if.stb = c; m0_if.we = we; m0_if.sel = sel; m0_if.adr = adr; m0_if.dat_w = dat;
    end else begin
      m1_if.cyc = c; m1_if.stb = c; m1_if.we = we; m1_if.sel = sel; m1_if.adr = adr; m1_if.dat_w = dat;
    end
  endtask
  task automatic test_reset();
    rstn = 0;
    idle_all();
    step();
    step();
    cmp++; if (grant !== 2'b00) begin err++; $display("FAIL reset grant: got %b want 00", grant); end
    cmp++; if (tmo !== 1'b0) begin err++; $display("FAIL reset timeout: got %b want 0", tmo); end
    cmp++; if (s_if.cyc !== 1'b0) begin err++; $display("FAIL reset s_cyc: got %b want 0", s_if.cyc); end
    rstn = 1;
  endtask
  task automatic test_m0_read();
    step();
    drive_m(0, 1, 0, 4'hF, 32'h10, 0);
    #1;
    cmp++; if (s_if.cyc !== 1'b0) begin err++; $display("FAIL m0_read latency s_cyc: got %b want 0", s_if.cyc); end
    step();
    cmp++; if (s_if.cyc !== 1'b1 || s_if.stb !== 1'b1) begin err++; $display("FAIL m0_read s_cyc/stb: got %b%b want 11", s_if.cyc, s_if.stb); end
    cmp++; if (grant !== 2'b01) begin err++; $display("FAIL m0_read grant: got %b want 01", grant); end
    cmp++; if (s_if.adr !== 32'h10) begin err++; $display("FAIL m0_read s_adr: got %h want 00000010", s_if.adr); end
    step();
    cmp++; if (m0_if.ack !== 1'b0) begin err++; $display("FAIL m0_read early ack: got %b want 0", m0_if.ack); end
    step();
    s_if.ack = 1; s_if.dat_r = 32'hCAFE0001;
    #1;
    cmp++; if (m0_if.ack !== 1'b1) begin err++; $display("FAIL m0_read ack: got %b want 1", m0_if.ack); end
    cmp++; if (m0_if.dat_r !== 32'hCAFE0001) begin err++; $display("FAIL m0_read data: got %h want cafe0001", m0_if.dat_r); end
    cmp++; if (m1_if.ack !== 1'b0 || m1_if.dat_r !== 32'h0) begin err++; $display("FAIL m0_read m1 leak: got ack %b data %h want 0/0", m1_if.ack, m1_if.dat_r); end
    step();
    idle_all();
    step();
    cmp++; if (grant !== 2'b00) begin err++; $display("FAIL m0_read release grant: got %b want 00", grant); end
  endtask
  task automatic test_tie();
    rstn = 0;
    step();
    rstn = 1;
    step();
    drive_m(0, 1, 0, 4'hF, 32'h20, 0);
    drive_m(1, 1, 1, 4'b0011, 32'h100, 32'h55);
    #1;
    cmp++; if (grant !== 2'b00) begin err++; $display("FAIL tie pre grant: got %b want 00", grant); end
    step();
    cmp++; if (grant !== 2'b01) begin err++; $display("FAIL tie first grant: got %b want 01", grant); end
    cmp++; if (s_if.adr !== 32'h20) begin err++; $display("FAIL tie m0 adr: got %h want 00000020", s_if.adr); end
    s_if.ack = 1; s_if.dat_r = 32'h1;
    #1;
    cmp++; if (m0_if.ack !== 1'b1 || m1_if.ack !== 1'b0) begin err++; $display("FAIL tie m0 beat acks: got %b%b want 01", m1_if.ack, m0_if.ack); end
    step();
    s_if.ack = 0;
    drive_m(0, 0, 0, 0, 0, 0);
    #1;
    cmp++; if (grant !== 2'b01 || s_if.cyc !== 1'b0) begin err++; $display("FAIL tie drop cycle: got grant %b cyc %b want 01/0", grant, s_if.cyc); end
    step();
    cmp++; if (grant !== 2'b10) begin err++; $display("FAIL tie switch grant: got %b want 10", grant); end
    cmp++; if (s_if.cyc !== 1'b1 || s_if.we !== 1'b1 || s_if.sel !== 4'b0011 || s_if.adr !== 32'h100 || s_if.dat_w !== 32'h55)
      begin err++; $display("FAIL tie m1 store: got cyc %b we %b sel %b adr %h dat %h want 1/1/0011/100/55", s_if.cyc, s_if.we, s_if.sel, s_if.adr, s_if.dat_w); end
    s_if.ack = 1;
    #1;
    cmp++; if (m1_if.ack !== 1'b1 || m0_if.ack !== 1'b0) begin err++; $display("FAIL tie m1 beat acks: got %b%b want 10", m1_if.ack, m0_if.ack); end
    step();
    idle_all();
    step();
    step();
  endtask
  task automatic test_alternate();
    logic [1:0] exp;
    step();
    drive_m(0, 1, 0, 4'hF, 32'h30, 0);
    drive_m(1, 1, 0, 4'hF, 32'h40, 0);
    step();
    for (int k = 0; k < 4; k++) begin
      exp = (k % 2) ? 2'b10 : 2'b01;
      #1;
      cmp++; if (grant !== exp) begin err++; $display("FAIL alternate grant %0d: got %b want %b", k, grant, exp); end
      s_if.ack = 1;
      #1;
      cmp++; if ({m1_if.ack, m0_if.ack} !== exp) begin err++; $display("FAIL alternate acks %0d: got %b want %b", k, {m1_if.ack, m0_if.ack}, exp); end
      step();
      s_if.ack = 0;
      drive_m(k % 2, 0, 0, 4'hF, 0, 0);
      step();
      drive_m(k % 2, 1, 0, 4'hF, (k % 2) ? 32'h40 : 32'h30, 0);
    end
    idle_all();
    step();
    step();
  endtask
  task automatic test_lock();
    step();
    drive_m(0, 1, 0, 4'hF, 32'h50, 0);
    step();
    drive_m(1, 1, 0, 4'hF, 32'h60, 0);
    for (int b = 0; b < 3; b++) begin
      m0_if.stb = 1; s_if.ack = 1;
      #1;
      cmp++; if (grant !== 2'b01) begin err++; $display("FAIL lock beat %0d grant: got %b want 01", b, grant); end
      cmp++; if (m0_if.ack !== 1'b1 || m1_if.ack !== 1'b0) begin err++; $display("FAIL lock beat %0d acks: got %b%b want 01", b, m1_if.ack, m0_if.ack); end
      step();
      m0_if.stb = 0; s_if.ack = 0;
      #1;
      cmp++; if (grant !== 2'b01 || m1_if.ack !== 1'b0) begin err++; $display("FAIL lock gap %0d: got grant %b m1ack %b want 01/0", b, grant, m1_if.ack); end
      step();
    end
    m0_if.cyc = 0;
    step();
    cmp++; if (grant !== 2'b10) begin err++; $display("FAIL lock handover grant: got %b want 10", grant); end
    s_if.ack = 1;
    #1;
    cmp++; if (m1_if.ack !== 1'b1) begin err++; $display("FAIL lock pending m1 ack: got %b want 1", m1_if.ack); end
    step();
    idle_all();
    step();
    step();
  endtask
  task automatic test_timeout();
    step();
    drive_m(1, 1, 0, 4'hF, 32'h70, 0);
    s_if.dat_r = 32'hDEADBEEF;
    step();
    for (int i = 1; i <= 4; i++) begin
      cmp++; if (m1_if.ack !== 1'b0 || s_if.stb !== 1'b1) begin err++; $display("FAIL timeout wait %0d: got ack %b stb %b want 0/1", i, m1_if.ack, s_if.stb); end
      step();
    end
    cmp++; if (m1_if.ack !== 1'b1 || m1_if.dat_r !== 32'h0) begin err++; $display("FAIL timeout forced ack: got ack %b data %h want 1/0", m1_if.ack, m1_if.dat_r); end
    cmp++; if (s_if.stb !== 1'b0 || s_if.cyc !== 1'b0) begin err++; $display("FAIL timeout bus drop: got cyc %b stb %b want 0/0", s_if.cyc, s_if.stb); end
    step();
    idle_all();
    #1;
    cmp++; if (tmo !== 1'b1) begin err++; $display("FAIL timeout flag: got %b want 1", tmo); end
    step();
    step();
    cmp++; if (tmo !== 1'b1) begin err++; $display("FAIL timeout sticky: got %b want 1", tmo); end
  endtask
  task automatic test_reset_mid();
    step();
    drive_m(1, 1, 1, 4'hF, 32'h80, 32'h77);
    step();
    cmp++; if (grant !== 2'b10) begin err++; $display("FAIL rstmid grant: got %b want 10", grant); end
    step();
    rstn = 0;
    #1;
    cmp++; if (m1_if.ack !== 1'b0) begin err++; $display("FAIL rstmid ack during reset: got %b want 0", m1_if.ack); end
    step();
    rstn = 1;
    s_if.ack = 1;
    #1;
    cmp++; if (s_if.cyc !== 1'b0) begin err++; $display("FAIL rstmid s_cyc: got %b want 0", s_if.cyc); end
    cmp++; if (grant !== 2'b00) begin err++; $display("FAIL rstmid grant after: got %b want 00", grant); end
    cmp++; if (tmo !== 1'b0) begin err++; $display("FAIL rstmid timeout: got %b want 0", tmo); end
    cmp++; if (m1_if.ack !== 1'b0 || m0_if.ack !== 1'b0) begin err++; $display("FAIL rstmid idle ack: got %b%b want 00", m1_if.ack, m0_if.ack); end
    idle_all();
    step();
    step();
  endtask
  initial begin
    idle_all();
    test_reset();
    test_m0_read();
    test_tie();
    test_alternate();
    test_lock();
    test_timeout();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
    $finish;
  end
endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 64, meaning max cycles a granted strobe waits for slave ack (0 = watchdog disabled).
REQ-002 SHALL have parameter BITSIZE, default 32, meaning address/data width.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rstn_i  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port wb_m0  wb_bus_t.slave  bundle  requester 0 (instruction fetch), higher initial priority.
REQ-006 SHALL have port wb_m1  wb_bus_t.slave  bundle  requester 1 (MEM-stage load/store unit).
REQ-007 SHALL have port wb_s  wb_bus_t.master  bundle  shared memory-side bus.
REQ-008 SHALL have port grant_o  output  2  one-hot current grant {m1,m0}; 00 when idle.
REQ-009 SHALL have port timeout_o  output  1  sticky flag, set on any watchdog expiry.

Function
REQ-010 SHALL implement FSM states IDLE, GNT_M0, GNT_M1; grant_o decodes the state.
REQ-011 IDLE: one cyc requester -> grant it next cycle; both -> grant master != last_q; none -> stay IDLE.
REQ-012 SHALL add exactly one cycle arbitration latency from cyc rise (in IDLE) to cyc/stb visible on wb_s.
REQ-013 GNT_Mx: wb_s cyc/stb/we/sel/adr/dat driven combinationally from master x; wb_s ack and read data routed to master x only.
REQ-014 Non-granted master SHALL see ack=0 and read data=0; its request held pending, never dropped.
REQ-015 IDLE: wb_s cyc, stb, we, sel, adr, dat all driven 0.
REQ-016 Bus lock: grant held while granted master keeps cyc high, across any number of stb/ack beats.
REQ-017 Granted master drops cyc: other master has cyc -> switch directly to its GNT state next cycle; else -> IDLE; last_q <= released master.
REQ-018 Watchdog counter SHALL count cycles with granted stb=1 and slave ack=0; cleared on ack, grant change or TIMEOUT=0.
REQ-019 Counter reaching TIMEOUT-1 with no ack: next cycle drive ack=1, read data=0 to granted master, force wb_s cyc/stb=0 that cycle, set timeout_o, clear counter.
REQ-020 Slave ack and watchdog expiry in same cycle: slave ack wins, timeout_o unchanged.
REQ-021 Counter SHALL saturate-free size $clog2(TIMEOUT+1) bits; no wrap possible before expiry.
REQ-022 Spurious slave ack in IDLE SHALL be ignored (routed to nobody).

Reset
REQ-023 rstn_i low at clk edge: state <= IDLE, last_q <= M1 (so M0 wins first tie), counter <= 0, timeout_o <= 0.
REQ-024 Reset mid-transaction SHALL deassert wb_s cyc/stb from the first cycle after the reset edge; no ack forwarded.
REQ-025 grant_o SHALL read 00 after reset.

Structure
REQ-026 State enum arb_state_e SHALL live in the shared core package; wb_bus_t stays as existing interface.
REQ-027 Watchdog SHALL be one sub-module wb_watchdog (inputs count_en, clear; output expire; parameter TIMEOUT).
REQ-028 Mux/routing logic SHALL remain in wb_arbiter; no other sub-modules.

Verification
REQ-029 m0 read, m1 idle, slave acks 2 cycles after stb -> wb_s cyc 1 cycle after m0 cyc, m0 gets ack+data 0xCAFE0001, grant_o=01.
REQ-030 m0 and m1 raise cyc same cycle after reset -> m0 granted first; on m0 cyc drop, grant_o 01->10 next cycle, m1 store (sel=0011, adr 0x100) reaches wb_s.
REQ-031 Both request continuously, single-beat each -> grants alternate 01,10,01,10; neither starved.
REQ-032 TIMEOUT=4, slave never acks -> m1 receives ack with data 0 on 5th cycle of stb, wb_s stb low that cycle, timeout_o=1 and stays 1.
REQ-033 m0 holds cyc across 3 beats while m1 requests -> grant stays 01 all 3 beats, m1 ack=0 throughout.
REQ-034 rstn_i low during granted m1 beat -> next cycle wb_s cyc=0, grant_o=00, timeout_o=0, m1 receives no ack.
